// File: rtl/trace_capture_pkg.sv
// Shared types and defaults for the trace_capture logic-analyser block.
// The capture FSM encoding lives here so the bench and any wrapper agree on it.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    localparam int DEFAULT_SAMPLES = 1280;
    localparam int DEFAULT_ADDR_W  = 11;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module trace_ram #(
    parameter int width      = 20,
    parameter int depth      = 1280,
    parameter int addr_width = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [width-1:0]      wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [width-1:0]      rdata
);

    logic [width-1:0] mem [depth];
    logic [width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Logic-analyser capture into trace memory plus column replay for the VGA waveform view.
// Optional pretrigger history is enabled by defining TRACE_CAPTURE_PRETRIG_EN.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int data_width = 20,
    parameter int samples    = DEFAULT_SAMPLES,
    parameter int addr_width = DEFAULT_ADDR_W,
    parameter int pretrig    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] probe,
    input  logic                  sample_stb,
    input  logic                  arm,
    input  logic [data_width-1:0] trig_mask,
    input  logic [data_width-1:0] trig_value,
    input  logic [10:0]           x,
    output logic [data_width-1:0] state,
    output logic [data_width-1:0] buf_data,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done
);

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(samples - 1);

    function automatic logic [addr_width-1:0] wrap_add(input logic [addr_width-1:0] a,
                                                      input logic [addr_width-1:0] b);
        logic [addr_width:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (addr_width+1)'(samples)) begin
            s = s - (addr_width+1)'(samples);
        end
        return s[addr_width-1:0];
    endfunction

    cap_state_e            fsm_q, fsm_d;
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] start;
    logic                  we;
    logic                  match;
    logic [addr_width-1:0] rd_addr;
    logic [data_width-1:0] rd_data;

    assign match = sample_stb && (((probe ^ trig_value) & trig_mask) == '0);

`ifdef TRACE_CAPTURE_PRETRIG_EN
    localparam logic [addr_width-1:0] PRE_CNT   = addr_width'(pretrig);
    localparam logic [addr_width-1:0] POST_LAST = addr_width'(samples - pretrig - 1);
    localparam logic [addr_width-1:0] BACK_OFS  = addr_width'(samples - pretrig);

    logic [addr_width-1:0] start_q, start_d;
    logic [addr_width-1:0] cnt_q, cnt_d;

    assign start = start_q;

    // ARMED counts history samples (saturating); CAPTURE counts post-trigger samples incl. trigger
    always_comb begin
        fsm_d    = fsm_q;
        wr_ptr_d = wr_ptr_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        if (arm) begin
            fsm_d    = ARMED;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            case (fsm_q)
                ARMED: begin
                    if (sample_stb) begin
                        we       = 1'b1;
                        wr_ptr_d = wrap_add(wr_ptr_q, addr_width'(1));
                        if (cnt_q != PRE_CNT) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (match) begin
                            start_d = wrap_add(wr_ptr_q, BACK_OFS);
                            cnt_d   = addr_width'(1);
                            fsm_d   = (POST_LAST == '0) ? DONE : CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_stb) begin
                        we       = 1'b1;
                        wr_ptr_d = wrap_add(wr_ptr_q, addr_width'(1));
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == POST_LAST) begin
                            fsm_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            cnt_q   <= '0;
        end else begin
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign start = '0;

    // Trigger sample lands at address 0 (pointer was cleared by arm)
    always_comb begin
        fsm_d    = fsm_q;
        wr_ptr_d = wr_ptr_q;
        we       = 1'b0;
        if (arm) begin
            fsm_d    = ARMED;
            wr_ptr_d = '0;
        end else begin
            case (fsm_q)
                ARMED: begin
                    if (match) begin
                        we = 1'b1;
                        if (wr_ptr_q == LAST_ADDR) begin
                            fsm_d = DONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            fsm_d    = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_stb) begin
                        we = 1'b1;
                        if (wr_ptr_q == LAST_ADDR) begin
                            fsm_d = DONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            wr_ptr_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign armed     = (fsm_q == ARMED);
    assign triggered = (fsm_q == CAPTURE);
    assign done      = (fsm_q == DONE);

    assign rd_addr = wrap_add(start, addr_width'(x));

    trace_ram #(
        .width     (data_width),
        .depth     (samples),
        .addr_width(addr_width)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr_q),
        .wdata(probe),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // Column tracker: jump_q makes buf_data follow the freshly read sample after a non-sequential x
    logic [10:0]           x_prev_q, x_prev_d;
    logic                  x_valid_q, x_valid_d;
    logic                  jump_q, jump_d;
    logic [data_width-1:0] hold_q, hold_d;
    logic                  x_inc, x_same;

    always_comb begin
        x_prev_d  = x;
        x_valid_d = (32'(x) < 32'(samples));
        x_inc     = (x == x_prev_q + 11'd1);
        x_same    = (x == x_prev_q);
        state     = x_valid_q ? rd_data : '0;
        buf_data  = !x_valid_q ? '0 : (jump_q ? state : hold_q);
        hold_d    = x_same ? buf_data : state;
        jump_d    = !x_valid_q || !(x_inc || x_same);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid_q <= 1'b0;
            jump_q    <= 1'b1;
        end else begin
            x_valid_q <= x_valid_d;
            jump_q    <= jump_d;
        end
        x_prev_q <= x_prev_d;
        hold_q   <= hold_d;
    end

endmodule
